// File: rtl/soc_mem_router_pkg.sv
// Shared types and constants for the SoC memory router and its address decoder.
// Region map: region 0 = IO, region 1 = instruction memory write port, region 2 = RAM.
package soc_bus_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} rt_state_t;

  // Width of the ACCESS watchdog counter.
  localparam int TO_W = 8;

  localparam logic [31:0] IO_FIRST    = 32'hC000_0000;
  localparam logic [31:0] IO_LAST     = 32'hC0FF_FFFF;
  localparam logic [31:0] INSTR_FIRST = 32'h0000_07D0;
  localparam logic [31:0] INSTR_LAST  = 32'h0000_1FC7;
  localparam logic [31:0] RAM_FIRST   = 32'h0000_0000;
  localparam logic [31:0] RAM_LAST    = 32'h0000_FFFF;

endpackage

// File: rtl/soc_mem_router_if.sv
// CPU load/store port of the router.
//   master : CPU side, drives m_req/m_we/m_addr/m_wdata/m_wstrb, receives m_rdata/m_ready/m_err
//   slave  : router side, the mirror image
interface soc_mem_router_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W/8-1:0] m_wstrb;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ready;
  logic              m_err;

  modport master (output m_req, m_we, m_addr, m_wdata, m_wstrb,
                  input  m_rdata, m_ready, m_err);
  modport slave  (input  m_req, m_we, m_addr, m_wdata, m_wstrb,
                  output m_rdata, m_ready, m_err);
endinterface

// File: rtl/soc_mem_router_decode.sv
// Table-driven address decoder (combinational), also used by the ICache fetch path.
//   addr : byte address
//   hit  : address falls in at least one region
//   idx  : lowest-numbered matching region
//   wp   : matching region is write-protectable (WP_MASK bit set)
module mem_region_decode
  import soc_bus_pkg::*;
#(
  parameter int NUM_REGIONS = 3,
  parameter int ADDR_W      = 32,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_FIRST = {RAM_FIRST, INSTR_FIRST, IO_FIRST},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LAST  = {RAM_LAST,  INSTR_LAST,  IO_LAST},
  parameter logic [NUM_REGIONS-1:0]        WP_MASK      = 3'b010,
  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx,
  output logic              wp
);

  // Scan from the top down so the lowest matching index is written last and wins.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (addr >= REGION_FIRST[i*ADDR_W +: ADDR_W] &&
          addr <= REGION_LAST[i*ADDR_W +: ADDR_W]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
    wp = hit & WP_MASK[idx];
  end

endmodule

// File: rtl/soc_mem_router.sv
// Address router between the CPU load/store port and NUM_REGIONS slaves.
//   clk, resetn : clock, asynchronous active-low reset
//   bus         : CPU port (req/ready handshake, m_err qualifies m_ready)
//   boot_done   : pulse, sets the sticky write lock; locked reflects it
//   s_sel/s_we/s_addr/s_wdata/s_wstrb : slave request, driven only from flops
//   s_rdata/s_ready : per-slave read data slots and completion
module soc_mem_router
  import soc_bus_pkg::*;
#(
  parameter int NUM_REGIONS = 3,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_FIRST = {RAM_FIRST, INSTR_FIRST, IO_FIRST},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LAST  = {RAM_LAST,  INSTR_LAST,  IO_LAST},
  parameter logic [NUM_REGIONS-1:0]        WP_MASK      = 3'b010,
  parameter int TIMEOUT = 255
) (
  input  logic                               clk,
  input  logic                               resetn,
  soc_mem_router_if.slave                    bus,
  input  logic                               boot_done,
  output logic                               locked,
  output logic [NUM_REGIONS-1:0]             s_sel,
  output logic                               s_we,
  output logic [ADDR_W-1:0]                  s_addr,
  output logic [DATA_W-1:0]                  s_wdata,
  output logic [DATA_W/8-1:0]                s_wstrb,
  input  logic [NUM_REGIONS-1:0][DATA_W-1:0] s_rdata,
  input  logic [NUM_REGIONS-1:0]             s_ready
);

  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

  rt_state_t           state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [TO_W-1:0]     cnt_q, cnt_d;
  logic                locked_q, locked_d;

  logic             dec_hit, dec_wp;
  logic [IDX_W-1:0] dec_idx;

  mem_region_decode #(
    .NUM_REGIONS (NUM_REGIONS),
    .ADDR_W      (ADDR_W),
    .REGION_FIRST(REGION_FIRST),
    .REGION_LAST (REGION_LAST),
    .WP_MASK     (WP_MASK)
  ) u_dec (
    .addr(bus.m_addr),
    .hit (dec_hit),
    .idx (dec_idx),
    .wp  (dec_wp)
  );

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state. The lock is only consulted when a request is accepted, so a
  // boot_done arriving mid-write lets that write finish.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.m_req) begin
        if (!dec_hit || (bus.m_we && locked_q && dec_wp)) state_d = ERR;
        else                                              state_d = ACCESS;
      end
      ACCESS: begin
        if (s_ready[idx_q])        state_d = RESP;
        else if (cnt_d == TO_LIM)  state_d = ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latches, watchdog counter, read capture, sticky lock
  always_comb begin
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    idx_d    = idx_q;
    rdata_d  = rdata_q;
    cnt_d    = '0;
    locked_d = locked_q | boot_done;
    if (state_q == IDLE && bus.m_req) begin
      addr_d  = bus.m_addr;
      we_d    = bus.m_we;
      wdata_d = bus.m_wdata;
      wstrb_d = bus.m_wstrb;
      idx_d   = dec_idx;
    end
    if (state_q == ACCESS) begin
      cnt_d = cnt_q + TO_W'(1);
      if (s_ready[idx_q]) rdata_d = we_q ? '0 : s_rdata[idx_q];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      idx_q    <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      idx_q    <= idx_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  // Outputs decode only state_q and the latches, so nothing on m_* reaches s_*
  // in the same cycle, and reset zeroes every output immediately.
  always_comb begin
    s_sel       = '0;
    s_we        = 1'b0;
    s_addr      = '0;
    s_wdata     = '0;
    s_wstrb     = '0;
    bus.m_ready = 1'b0;
    bus.m_err   = 1'b0;
    bus.m_rdata = '0;
    unique case (state_q)
      ACCESS: begin
        s_sel[idx_q] = 1'b1;
        s_we         = we_q;
        s_addr       = addr_q;
        if (we_q) begin
          s_wdata = wdata_q;
          s_wstrb = wstrb_q;
        end
      end
      RESP: begin
        bus.m_ready = 1'b1;
        bus.m_rdata = rdata_q;
      end
      ERR: begin
        bus.m_ready = 1'b1;
        bus.m_err   = 1'b1;
      end
      default: ;
    endcase
  end

  assign locked = locked_q;

endmodule

// File: tb/tb_soc_mem_router.sv
module tb_soc_mem_router;

  localparam int TIMEOUT = 255;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          issue;
  } mexp_t;

  typedef struct {
    int          slot;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          delay;   // sel cycles before ready; negative = slave never answers
    logic [31:0] rdata;
  } sexp_t;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             boot_done = 1'b0;
  logic             locked;
  logic [2:0]       s_sel;
  logic             s_we;
  logic [31:0]      s_addr;
  logic [31:0]      s_wdata;
  logic [3:0]       s_wstrb;
  logic [2:0][31:0] s_rdata = '0;
  logic [2:0]       s_ready = '0;

  soc_mem_router_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  soc_mem_router dut (
    .clk(clk), .resetn(resetn), .bus(bus), .boot_done(boot_done), .locked(locked),
    .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rdata(s_rdata), .s_ready(s_ready)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    in_rst = 1'b1;
  bit    locked_m = 1'b0;
  mexp_t mq[$];
  sexp_t sq[$];

  // Region table in spec order: 0 = IO, 1 = instruction memory, 2 = RAM.
  logic [31:0] reg_first [3] = '{32'hC000_0000, 32'h0000_07D0, 32'h0000_0000};
  logic [31:0] reg_last  [3] = '{32'hC0FF_FFFF, 32'h0000_1FC7, 32'h0000_FFFF};
  bit          reg_wp    [3] = '{1'b0, 1'b1, 1'b0};

  function automatic int region_of(logic [31:0] a);
    for (int i = 0; i < 3; i++)
      if (a >= reg_first[i] && a <= reg_last[i]) return i;
    return -1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_sel"},    32'(s_sel), 0);
    chk({tag, "_swe"},    32'(s_we), 0);
    chk({tag, "_saddr"},  s_addr, 0);
    chk({tag, "_swdata"}, s_wdata, 0);
    chk({tag, "_swstrb"}, 32'(s_wstrb), 0);
    chk({tag, "_mready"}, 32'(bus.m_ready), 0);
    chk({tag, "_merr"},   32'(bus.m_err), 0);
    chk({tag, "_mrdata"}, bus.m_rdata, 0);
    chk({tag, "_locked"}, 32'(locked), 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Issue one request, push expectations, wait for completion.
  task automatic do_req(logic we, logic [31:0] addr, logic [31:0] wdata, logic [3:0] wstrb,
                        int delay, logic [31:0] rdata, bit keep);
    int    r;
    bit    err, seen;
    mexp_t m;
    sexp_t s;
    r   = region_of(addr);
    err = (r < 0) || (we && locked_m && reg_wp[r]);
    m.err   = err || (delay < 0);
    m.rdata = (m.err || we) ? 32'h0 : rdata;
    m.lat   = err ? 1 : (delay < 0) ? TIMEOUT + 1 : delay + 2;
    m.issue = cyc;
    mq.push_back(m);
    if (!err) begin
      s.slot = r; s.we = we; s.addr = addr; s.wdata = wdata; s.wstrb = wstrb;
      s.delay = delay; s.rdata = rdata;
      sq.push_back(s);
    end
    bus.m_req = 1'b1; bus.m_we = we; bus.m_addr = addr;
    bus.m_wdata = wdata; bus.m_wstrb = wstrb;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = bus.m_ready;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL req_wait act=no_m_ready exp=m_ready addr=%h", addr);
    end
    @(negedge clk);
    if (!keep) bus.m_req = 1'b0;
  endtask

  // Master-side monitor
  initial forever begin
    mexp_t m;
    @(negedge clk);
    if (!in_rst && resetn) begin
      if (bus.m_ready) begin
        if (mq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_m_ready act=1 exp=0 (t=%0t)", $time);
        end else begin
          m = mq.pop_front();
          chk("m_err", 32'(bus.m_err), 32'(m.err));
          chk("m_rdata", bus.m_rdata, m.rdata);
          chk("m_latency", 32'(cyc - m.issue), 32'(m.lat));
        end
      end else begin
        chk("idle_m_err", 32'(bus.m_err), 0);
        chk("idle_m_rdata", bus.m_rdata, 0);
      end
    end
  end

  // Slave responder + slave-side checker
  bit    s_active = 1'b0;
  bit    s_bogus = 1'b0;
  int    s_cnt = 0;
  sexp_t s_cur;
  initial forever begin
    logic [2:0] oh;
    @(negedge clk);
    if (in_rst || !resetn) begin
      s_active = 1'b0;
      s_ready  = '0;
      s_rdata  = '0;
    end else if (s_sel != 3'b000) begin
      if (!s_active) begin
        s_active = 1'b1;
        s_cnt = 0;
        if (sq.size() == 0) begin
          checks++; errors++;
          s_bogus = 1'b1;
          $display("FAIL unexpected_s_sel act=%b exp=000 addr=%h", s_sel, s_addr);
        end else begin
          s_bogus = 1'b0;
          s_cur = sq.pop_front();
          oh = 3'b001 << s_cur.slot;
          chk("s_sel", 32'(s_sel), 32'(oh));
          chk("s_we", 32'(s_we), 32'(s_cur.we));
          chk("s_addr", s_addr, s_cur.addr);
          chk("s_wdata", s_wdata, s_cur.we ? s_cur.wdata : 32'h0);
          chk("s_wstrb", 32'(s_wstrb), s_cur.we ? 32'(s_cur.wstrb) : 32'h0);
        end
      end
      s_cnt++;
      for (int i = 0; i < 3; i++) s_rdata[i] = $urandom;
      if (s_bogus) begin
        s_ready = '0;
      end else begin
        oh = 3'b001 << s_cur.slot;
        // other slots get random ready noise, the selected one fires on schedule
        s_ready = 3'($urandom) & ~oh;
        if (s_cur.delay >= 0 && s_cnt >= s_cur.delay + 1) s_ready = s_ready | oh;
        s_rdata[s_cur.slot] = s_cur.rdata;
      end
    end else begin
      if (s_active && !s_bogus)
        chk("sel_cycles", 32'(s_cnt), s_cur.delay < 0 ? 32'(TIMEOUT) : 32'(s_cur.delay + 1));
      s_active = 1'b0;
      s_ready  = 3'($urandom);
      for (int i = 0; i < 3; i++) s_rdata[i] = $urandom;
    end
  end

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 11))
      0:  return 32'h0000_07D0;
      1:  return 32'h0000_07CF;
      2:  return 32'h0000_1FC7;
      3:  return 32'h0000_1FC8;
      4:  return 32'h0000_FFFF;
      5:  return 32'h0001_0000;
      6:  return 32'hC0FF_FFFF;
      7:  return 32'hC100_0000;
      8:  return 32'hBFFF_FFFF;
      9:  return 32'($urandom_range(0, 32'h0000_FFFF));
      10: return 32'hC000_0000 + 32'($urandom_range(0, 32'h00FF_FFFF));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.m_req = 1'b0; bus.m_we = 1'b0; bus.m_addr = '0; bus.m_wdata = '0; bus.m_wstrb = '0;
    #12;
    chk_zero("reset");
    @(negedge clk); resetn = 1'b1;
    @(negedge clk); in_rst = 1'b0;

    // RAM read, ready two cycles after select
    do_req(1'b0, 32'h0000_0100, 32'h0, 4'h0, 2, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    // instruction write before the lock, boot_done pulsed during the access
    fork
      do_req(1'b1, 32'h0000_07D0, 32'h1234_5678, 4'hF, 3, 32'h0, 1'b0);
      begin
        @(negedge clk); @(negedge clk);
        boot_done = 1'b1;
        @(negedge clk);
        boot_done = 1'b0;
        locked_m = 1'b1;
      end
    join
    chk("locked_after_boot", 32'(locked), 1);
    // same write now write-protected
    do_req(1'b1, 32'h0000_07D0, 32'h1234_5678, 4'hF, 0, 32'h0, 1'b0);
    // unmapped read
    do_req(1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, 32'h0, 1'b0);
    // IO read, slave never answers
    do_req(1'b0, 32'hC000_0004, 32'h0, 4'h0, -1, 32'h0, 1'b0);
    // back-to-back RAM reads with immediate ready
    do_req(1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, 32'hA5A5_0001, 1'b1);
    do_req(1'b0, 32'h0000_0044, 32'h0, 4'h0, 0, 32'hA5A5_0002, 1'b0);

    for (int n = 0; n < 60; n++) begin
      logic        we;
      int          dly;
      bit          keep;
      we   = 1'($urandom);
      dly  = ($urandom_range(0, 24) == 0) ? -1 : int'($urandom_range(0, 4));
      keep = (n < 59) && ($urandom_range(0, 1) == 1);
      do_req(we, pick_addr(), $urandom, 4'($urandom), dly, $urandom, keep);
      if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset in the middle of an access
    @(negedge clk);
    in_rst = 1'b1;
    mq.delete(); sq.delete();
    bus.m_we = 1'b0; bus.m_addr = 32'h0000_0200; bus.m_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_sel", 32'(s_sel), 32'b100);
    chk("pre_rst_locked", 32'(locked), 1);
    bus.m_req = 1'b0;
    #2 resetn = 1'b0;
    #1 chk_zero("mid_rst");
    locked_m = 1'b0;
    @(negedge clk); resetn = 1'b1;
    @(negedge clk); in_rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("post_rst_locked", 32'(locked), 0);
    // lock cleared: instruction write goes through again
    do_req(1'b1, 32'h0000_07D0, 32'hCAFE_F00D, 4'h3, 1, 32'h0, 1'b0);
    repeat (4) @(negedge clk);
    if (mq.size() != 0 || sq.size() != 0) begin
      checks++; errors++;
      $display("FAIL leftover_expectations act=%0d/%0d exp=0/0", mq.size(), sq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
